pass_request_gen: RTL and testbench

- Upstream stage of the traffic_light controller; sole source of its `pass` input.
- Conditions a raw, asynchronous push-button into a clean pass request: 2-FF synchronizer, then debounce, then a one-shot pulse.
- A lockout window follows each accepted press, so repeated presses cannot hold the light in green indefinitely.
- Reports a busy flag and a saturating accepted-press counter for status readout.

---
 rtl/traffic_pkg.sv | 14 +
 rtl/btn_debounce.sv | 49 ++++
 rtl/pass_request_gen.sv | 95 +++++++++
 tb/tb_pass_request_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the traffic light front end.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    LOCKOUT  = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_LOCKOUT_CYCLES  = 2048;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability counter.
// The output only changes after DEBOUNCE_CYCLES consecutive cycles of
// disagreement, so shorter glitches never reach it.
module btn_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync_a;
  logic       sync_b;
  logic [7:0] cnt;

  // Bring the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= din;
      sync_b <= sync_a;
    end
  end

  // Count cycles of disagreement; toggle the output when the run is long enough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= 8'd0;
      dout <= 1'b0;
    end else if (sync_b != dout) begin
      if (cnt == CNT_LAST) begin
        cnt  <= 8'd0;
        dout <= ~dout;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end else begin
      cnt <= 8'd0;
    end
  end

endmodule

// File: rtl/pass_request_gen.sv
// Turns a bouncy push-button into a single-cycle pass request with a
// lockout window, a busy flag and a saturating accepted-press counter.
module pass_request_gen
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic             enable,
  output logic             pass,
  output logic             busy,
  output logic [CNT_W-1:0] req_count
);

  localparam logic [15:0] LOCK_LOAD = 16'(LOCKOUT_CYCLES - 1);

  logic        btn_db;
  logic        btn_db_q;
  logic        rise;
  logic [15:0] lock_cnt;
  state_t      state;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .din (btn_raw),
    .dout(btn_db)
  );

  // Delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
    end
  end

  assign rise = btn_db & ~btn_db_q;

  // Request FSM; pass and busy are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pass      <= 1'b0;
      busy      <= 1'b0;
      lock_cnt  <= 16'd0;
      req_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise && enable) begin
            state <= PULSE;
            pass  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        PULSE: begin
          pass     <= 1'b0;
          lock_cnt <= LOCK_LOAD;
          if (req_count != '1) begin
            req_count <= req_count + 1'b1;
          end
          state <= LOCKOUT;
        end
        LOCKOUT: begin
          if (lock_cnt == 16'd0) begin
            state <= WAIT_REL;
          end else begin
            lock_cnt <= lock_cnt - 16'd1;
          end
        end
        WAIT_REL: begin
          // A button held through lockout must be released before re-arming.
          if (!btn_db) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          pass  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pass_request_gen.sv
// Scoreboard bench for pass_request_gen (DEBOUNCE=4, LOCKOUT=8).
// Stimulus pushes the expected pulse cycle and count; monitors pop on pass.
module tb_pass_request_gen;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       raw_a = 1'b0;
  logic       en_a = 1'b1;
  logic       pass_a;
  logic       busy_a;
  logic [7:0] cnt_a;
  logic       raw_b = 1'b0;
  logic       en_b = 1'b1;
  logic       pass_b;
  logic       busy_b;
  logic [1:0] cnt_b;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t qa[$];
  exp_t qb[$];
  bit   pend_a = 0;
  bit   pend_b = 0;
  int   want_a = 0;
  int   want_b = 0;

  pass_request_gen #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .btn_raw(raw_a), .enable(en_a),
    .pass(pass_a), .busy(busy_a), .req_count(cnt_a)
  );

  pass_request_gen #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .btn_raw(raw_b), .enable(en_b),
    .pass(pass_b), .busy(busy_b), .req_count(cnt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor A: each pass pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (pend_a) begin
      check("count_a", int'(cnt_a), want_a);
      pend_a = 0;
    end
    if (pass_a === 1'b1) begin
      if (qa.size() == 0) begin
        check("unexpected_pass_a", 1, 0);
      end else begin
        e = qa.pop_front();
        check("pass_cycle_a", cyc, e.cyc);
        want_a = e.cnt;
        pend_a = 1;
      end
    end
  end

  // Monitor B: same scheme for the 2-bit counter instance.
  always @(negedge clk) begin
    exp_t e;
    if (pend_b) begin
      check("count_b", int'(cnt_b), want_b);
      pend_b = 0;
    end
    if (pass_b === 1'b1) begin
      if (qb.size() == 0) begin
        check("unexpected_pass_b", 1, 0);
      end else begin
        e = qb.pop_front();
        check("pass_cycle_b", cyc, e.cyc);
        want_b = e.cnt;
        pend_b = 1;
      end
    end
  end

  task automatic push_a(input int cnt);
    exp_t e;
    e.cyc = cyc + 7;
    e.cnt = cnt;
    qa.push_back(e);
  endtask

  task automatic press_a(input int hold, input bit expect_pulse, input int cnt);
    raw_a = 1'b1;
    if (expect_pulse) push_a(cnt);
    step(hold);
    raw_a = 1'b0;
  endtask

  task automatic press_b(input int hold, input int cnt);
    exp_t e;
    raw_b = 1'b1;
    e.cyc = cyc + 7;
    e.cnt = cnt;
    qb.push_back(e);
    step(hold);
    raw_b = 1'b0;
  endtask

  task automatic wait_idle_a(input int limit);
    int n = 0;
    while (busy_a && n < limit) begin
      step(1);
      n++;
    end
    check("idle_timeout_a", int'(busy_a), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_pass", int'(pass_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_count", int'(cnt_a), 0);
    step(2);
    rst = 1'b1;
    step(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rel;
    #2;
    check("init_pass", int'(pass_a), 0);
    check("init_busy", int'(busy_a), 0);
    check("init_count", int'(cnt_a), 0);
    step(3);
    rst = 1'b1;
    step(3);

    // Clean press held 30 cycles.
    raw_a = 1'b1;
    push_a(1);
    step(6);
    check("clean_busy_e6", int'(busy_a), 0);
    step(1);
    check("clean_busy_e7", int'(busy_a), 1);
    step(23);
    raw_a = 1'b0;
    step(6);
    check("clean_busy_rel6", int'(busy_a), 1);
    step(1);
    check("clean_busy_rel7", int'(busy_a), 0);
    step(5);
    check("clean_count", int'(cnt_a), 1);

    // Bounce: highs of 1, 2, 3 cycles separated by single lows.
    do_reset();
    raw_a = 1'b1; step(1); raw_a = 1'b0; step(1);
    raw_a = 1'b1; step(2); raw_a = 1'b0; step(1);
    raw_a = 1'b1; step(3); raw_a = 1'b0; step(1);
    press_a(20, 1, 1);
    step(10);
    wait_idle_a(40);
    check("bounce_count", int'(cnt_a), 1);

    // Lockout: release after 6, re-press during lockout, then a third press.
    do_reset();
    press_a(6, 1, 1);
    step(4);
    press_a(10, 0, 0);
    step(10);
    wait_idle_a(40);
    check("lockout_count1", int'(cnt_a), 1);
    step(3);
    press_a(10, 1, 2);
    step(10);
    wait_idle_a(40);
    check("lockout_count2", int'(cnt_a), 2);

    // Held button for 100 cycles.
    do_reset();
    press_a(100, 1, 1);
    rel = cyc;
    step(6);
    check("held_busy_rel6", int'(busy_a), 1);
    step(1);
    check("held_busy_rel7", int'(busy_a), 0);
    check("held_rel_cycle", cyc - rel, 7);
    step(5);

    // Press with enable low is discarded.
    do_reset();
    en_a = 1'b0;
    press_a(15, 0, 0);
    step(15);
    check("disabled_count", int'(cnt_a), 0);
    check("disabled_busy", int'(busy_a), 0);
    en_a = 1'b1;

    // Reset mid-lockout, button still held afterwards.
    raw_a = 1'b1;
    push_a(1);
    step(10);
    check("midlock_busy", int'(busy_a), 1);
    rst = 1'b0;
    #1;
    check("async_rst_pass", int'(pass_a), 0);
    check("async_rst_busy", int'(busy_a), 0);
    check("async_rst_count", int'(cnt_a), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_a(1);
    step(20);
    raw_a = 1'b0;
    step(10);
    wait_idle_a(40);
    check("rehold_count", int'(cnt_a), 1);

    // Saturation on the 2-bit counter instance.
    for (int i = 0; i < 5; i++) begin
      press_b(6, (i < 3) ? i + 1 : 3);
      step(25);
    end
    check("sat_count", int'(cnt_b), 3);
    check("sat_busy", int'(busy_b), 0);

    step(5);
    check("missed_pulses_a", qa.size(), 0);
    check("missed_pulses_b", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
